// File: rtl/bar_viz_pkg.sv
// Shared colours, animation states and bar-height scaling for the animated
// bar-chart renderer.
package bar_viz_pkg;

  localparam logic [15:0] COL_BLACK  = 16'h0000;
  localparam logic [15:0] COL_BLUE   = 16'h001F;
  localparam logic [15:0] COL_YELLOW = 16'hFFE0;
  localparam logic [15:0] COL_RED    = 16'hF800;
  localparam logic [15:0] COL_GREEN  = 16'h07E0;
  localparam logic [15:0] COL_WHITE  = 16'hFFFF;
  localparam logic [15:0] COL_DGREY  = 16'h4208;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_ANIM  = 2'd1,
    DONE_SWEEP = 2'd2
  } anim_state_e;

  typedef logic [13:0] coord_t;

  // Full-width product then truncating divide; hmax and val_w are always
  // elaboration constants, so this folds to a multiply by a constant reciprocal.
  function automatic coord_t bar_height(input logic [31:0] v,
                                        input int unsigned hmax,
                                        input int unsigned val_w);
    logic [63:0] prod;
    logic [63:0] den;
    prod = {32'd0, v} * {32'd0, hmax};
    den  = (64'd1 << val_w) - 64'd1;
    return coord_t'(prod / den);
  endfunction

endpackage

// File: rtl/bar_anim_ctrl.sv
// Frame-rate controller: swap capture, frame-synchronous snapshot of the
// array, swap-animation step counter and the done-sweep progress counter.
module bar_anim_ctrl
  import bar_viz_pkg::*;
#(
  parameter int NUM_BARS    = 6,
  parameter int VAL_W       = 8,
  parameter int ANIM_FRAMES = 8,
  parameter int DONE_STEP   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic [NUM_BARS*VAL_W-1:0] array_flat,
  input  logic [3:0]                compare_idx1,
  input  logic [3:0]                compare_idx2,
  input  logic                      swap_flag,
  input  logic                      done,
  output logic [NUM_BARS*VAL_W-1:0] snapshot,
  output anim_state_e               state,
  output logic [7:0]                anim_step,
  output logic [4:0]                sweep_cnt,
  output logic [3:0]                lo,
  output logic [3:0]                hi,
  output logic                      anim_busy
);

  localparam logic [7:0] LAST_STEP  = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0] LAST_FRAME = 8'(DONE_STEP - 1);
  localparam logic [4:0] SWEEP_MAX  = 5'(NUM_BARS);

  logic       swap_q;
  logic       swap_pending;
  logic       swap_rise;
  logic [7:0] frame_cnt;

  assign swap_rise = swap_flag & ~swap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_q       <= 1'b0;
      swap_pending <= 1'b0;
      lo           <= 4'd0;
      hi           <= 4'd0;
      snapshot     <= '0;
      state        <= IDLE;
      anim_step    <= 8'd0;
      sweep_cnt    <= 5'd0;
      frame_cnt    <= 8'd0;
      anim_busy    <= 1'b0;
    end else begin
      swap_q <= swap_flag;

      // Only the first edge of a swap is remembered until it has been animated.
      if (swap_rise && !swap_pending && state != SWAP_ANIM) begin
        swap_pending <= 1'b1;
        lo           <= (compare_idx1 < compare_idx2) ? compare_idx1 : compare_idx2;
        hi           <= (compare_idx1 < compare_idx2) ? compare_idx2 : compare_idx1;
      end

      if (frame_tick) begin
        case (state)
          IDLE: begin
            if (!swap_pending) snapshot <= array_flat;
            if (done) begin
              state        <= DONE_SWEEP;
              swap_pending <= 1'b0;
              sweep_cnt    <= 5'd0;
              frame_cnt    <= 8'd0;
            end else if (swap_pending) begin
              state        <= SWAP_ANIM;
              anim_step    <= 8'd0;
              swap_pending <= 1'b0;
              anim_busy    <= 1'b1;
            end
          end
          SWAP_ANIM: begin
            if (anim_step == LAST_STEP) begin
              state     <= IDLE;
              anim_step <= 8'd0;
              snapshot  <= array_flat;
              anim_busy <= 1'b0;
            end else begin
              anim_step <= anim_step + 8'd1;
            end
          end
          DONE_SWEEP: begin
            if (!done) begin
              state     <= IDLE;
              sweep_cnt <= 5'd0;
              frame_cnt <= 8'd0;
            end else if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= 8'd0;
              if (sweep_cnt != SWEEP_MAX) sweep_cnt <= sweep_cnt + 5'd1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/bar_renderer_anim.sv
// Two-stage pixel pipeline drawing frame-synchronous bars, sliding swap
// animation, baseline and status row for the 96x64 RGB565 OLED.
module bar_renderer_anim
  import bar_viz_pkg::*;
#(
  parameter int NUM_BARS       = 6,
  parameter int VAL_W          = 8,
  parameter int WIDTH          = 96,
  parameter int HEIGHT         = 64,
  parameter int BAR_HEIGHT_MAX = 60,
  parameter int BAR_GAP        = 2,
  parameter int ANIM_FRAMES    = 8,
  parameter int DONE_STEP      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic [13:0]               pixel_index,
  input  logic [NUM_BARS*VAL_W-1:0] array_flat,
  input  logic [3:0]                compare_idx1,
  input  logic [3:0]                compare_idx2,
  input  logic                      swap_flag,
  input  logic                      sorting,
  input  logic                      done,
  output logic [15:0]               pixel_data,
  output logic                      anim_busy
);

  localparam int     SLOT  = WIDTH / NUM_BARS;
  localparam int     BAR_W = SLOT - BAR_GAP;
  localparam coord_t W14   = coord_t'(WIDTH);
  localparam coord_t S14   = coord_t'(SLOT);
  localparam coord_t BW14  = coord_t'(BAR_W);
  localparam coord_t NB14  = coord_t'(NUM_BARS);
  localparam coord_t BHM14 = coord_t'(BAR_HEIGHT_MAX);
  localparam logic [31:0] NUM_PIX = 32'(WIDTH * HEIGHT);

  logic [NUM_BARS*VAL_W-1:0] snapshot;
  anim_state_e               state;
  logic [7:0]                anim_step;
  logic [4:0]                sweep_cnt;
  logic [3:0]                lo;
  logic [3:0]                hi;

  bar_anim_ctrl #(
    .NUM_BARS    (NUM_BARS),
    .VAL_W       (VAL_W),
    .ANIM_FRAMES (ANIM_FRAMES),
    .DONE_STEP   (DONE_STEP)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .array_flat   (array_flat),
    .compare_idx1 (compare_idx1),
    .compare_idx2 (compare_idx2),
    .swap_flag    (swap_flag),
    .done         (done),
    .snapshot     (snapshot),
    .state        (state),
    .anim_step    (anim_step),
    .sweep_cnt    (sweep_cnt),
    .lo           (lo),
    .hi           (hi),
    .anim_busy    (anim_busy)
  );

  // Stage 1: coordinates, slot membership and the three heights of interest.
  coord_t             x_c, y_c, slot_c, col_c;
  coord_t             h_slot_c, h_lo_c, h_hi_c;
  logic               valid_c, bar_col_c;
  logic [VAL_W-1:0]   v_slot, v_lo, v_hi;

  always_comb begin
    valid_c   = {18'd0, pixel_index} < NUM_PIX;
    x_c       = pixel_index % W14;
    y_c       = pixel_index / W14;
    slot_c    = x_c / S14;
    col_c     = x_c - slot_c * S14;
    bar_col_c = (slot_c < NB14) && (col_c < BW14);
    v_slot    = '0;
    v_lo      = '0;
    v_hi      = '0;
    for (int b = 0; b < NUM_BARS; b++) begin
      if (slot_c == coord_t'(b)) v_slot = snapshot[b*VAL_W +: VAL_W];
      if (lo == 4'(b))           v_lo   = snapshot[b*VAL_W +: VAL_W];
      if (hi == 4'(b))           v_hi   = snapshot[b*VAL_W +: VAL_W];
    end
    h_slot_c = bar_height(32'(v_slot), BAR_HEIGHT_MAX, VAL_W);
    h_lo_c   = bar_height(32'(v_lo),   BAR_HEIGHT_MAX, VAL_W);
    h_hi_c   = bar_height(32'(v_hi),   BAR_HEIGHT_MAX, VAL_W);
  end

  logic   s1_valid, s1_bar_col;
  coord_t s1_x, s1_y, s1_slot, s1_h_slot, s1_h_lo, s1_h_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_bar_col <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_slot    <= '0;
      s1_h_slot  <= '0;
      s1_h_lo    <= '0;
      s1_h_hi    <= '0;
    end else begin
      s1_valid   <= valid_c;
      s1_bar_col <= bar_col_c;
      s1_x       <= x_c;
      s1_y       <= y_c;
      s1_slot    <= slot_c;
      s1_h_slot  <= h_slot_c;
      s1_h_lo    <= h_lo_c;
      s1_h_hi    <= h_hi_c;
    end
  end

  // Stage 2: colour. Moving bars own their whole column span while animating.
  logic [31:0] off, lo_x, hi_x, xx, rise;
  logic        anim, in_lo, in_hi, fill_mov, edge_mov, hide_slot, compared;
  logic [15:0] bar_colour, colour;

  always_comb begin
    anim      = (state == SWAP_ANIM);
    off       = ((32'(hi) - 32'(lo)) * 32'(SLOT) * 32'(anim_step)) / 32'(ANIM_FRAMES);
    lo_x      = 32'(lo) * 32'(SLOT) + off;
    hi_x      = 32'(hi) * 32'(SLOT) - off;
    xx        = 32'(s1_x);
    rise      = 32'(BAR_HEIGHT_MAX) - 32'(s1_y);
    in_lo     = anim && (xx >= lo_x) && (xx < lo_x + 32'(BAR_W));
    in_hi     = anim && (xx >= hi_x) && (xx < hi_x + 32'(BAR_W));
    fill_mov  = (in_lo && rise < 32'(s1_h_lo)) || (in_hi && rise < 32'(s1_h_hi));
    edge_mov  = (in_lo && s1_h_lo != '0 && rise == 32'(s1_h_lo)) ||
                (in_hi && s1_h_hi != '0 && rise == 32'(s1_h_hi));
    hide_slot = anim && (s1_slot == coord_t'(lo) || s1_slot == coord_t'(hi));
    compared  = (s1_slot == coord_t'(compare_idx1)) || (s1_slot == coord_t'(compare_idx2));

    if (done && s1_slot < coord_t'(sweep_cnt)) bar_colour = COL_GREEN;
    else if (swap_flag && compared)            bar_colour = COL_RED;
    else if (sorting && compared)              bar_colour = COL_YELLOW;
    else                                       bar_colour = COL_BLUE;

    colour = COL_BLACK;
    if (!s1_valid) begin
      colour = COL_BLACK;
    end else if (s1_y < BHM14) begin
      if (in_lo || in_hi) begin
        colour = fill_mov ? COL_RED : (edge_mov ? COL_WHITE : COL_BLACK);
      end else if (s1_bar_col && !hide_slot) begin
        if (rise < 32'(s1_h_slot))                              colour = bar_colour;
        else if (s1_h_slot != '0 && rise == 32'(s1_h_slot))     colour = COL_WHITE;
      end
    end else if (s1_y == BHM14) begin
      colour = COL_WHITE;
    end else if (s1_y == BHM14 + coord_t'(1)) begin
      if (done) begin
        if (xx < 32'(sweep_cnt) * 32'(SLOT)) colour = COL_GREEN;
      end else if (sorting) begin
        if (s1_x >= coord_t'(32) && s1_x <= coord_t'(63)) colour = COL_YELLOW;
      end else begin
        if (s1_x >= coord_t'(40) && s1_x <= coord_t'(55)) colour = COL_DGREY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pixel_data <= 16'h0000;
    else        pixel_data <= colour;
  end

endmodule

// File: tb/tb_bar_renderer_anim.sv
// Directed and randomized checks of the animated bar renderer against a
// frame-buffer painting model of the display.
module tb_bar_renderer_anim;

  localparam int NB = 6, VW = 8, W = 96, H = 64, BHM = 60, GAP = 2;
  localparam int AF = 8, DS = 4, SLOT = 16;
  localparam int MI = 0, MA = 1, MS = 2;

  localparam logic [15:0] C_BLACK  = 16'h0000;
  localparam logic [15:0] C_BLUE   = 16'h001F;
  localparam logic [15:0] C_YELLOW = 16'hFFE0;
  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;
  localparam logic [15:0] C_DGREY  = 16'h4208;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [13:0] pixel_index = '0;
  logic [47:0] array_flat = '0;
  logic [3:0]  compare_idx1 = '0;
  logic [3:0]  compare_idx2 = '0;
  logic        swap_flag = 1'b0;
  logic        sorting = 1'b0;
  logic        done = 1'b0;
  logic [15:0] pixel_data;
  logic        anim_busy;

  bar_renderer_anim dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .pixel_index  (pixel_index),
    .array_flat   (array_flat),
    .compare_idx1 (compare_idx1),
    .compare_idx2 (compare_idx2),
    .swap_flag    (swap_flag),
    .sorting      (sorting),
    .done         (done),
    .pixel_data   (pixel_data),
    .anim_busy    (anim_busy)
  );

  always #5 clk = ~clk;

  // Reference model state: what the display should show, per the frame rules.
  int          m_snap [NB];
  int          m_mode, m_step, m_sweep_frames, m_lo, m_hi;
  bit          m_pending;
  logic [15:0] fb [H][W];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int hgt(input int v);
    return (v * BHM) / 255;
  endfunction

  function automatic int arr_val(input int b);
    return int'(array_flat[b*VW +: VW]);
  endfunction

  function automatic void paint();
    int sweep, hb, off;
    int sx [2];
    int hh [2];
    logic [15:0] col;
    sweep = 0;
    if (m_mode == MS) sweep = (m_sweep_frames / DS < NB) ? m_sweep_frames / DS : NB;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fb[y][x] = C_BLACK;
    for (int b = 0; b < NB; b++) begin
      if (m_mode == MA && (b == m_lo || b == m_hi)) continue;
      if (done && b < sweep) col = C_GREEN;
      else if (swap_flag && (b == int'(compare_idx1) || b == int'(compare_idx2))) col = C_RED;
      else if (sorting && (b == int'(compare_idx1) || b == int'(compare_idx2))) col = C_YELLOW;
      else col = C_BLUE;
      hb = hgt(m_snap[b]);
      for (int c = b * SLOT; c < b * SLOT + SLOT - GAP; c++)
        for (int r = 1; r <= BHM; r++) begin
          if (r < hb) fb[BHM-r][c] = col;
          else if (r == hb && hb > 0) fb[BHM-r][c] = C_WHITE;
        end
    end
    if (m_mode == MA) begin
      off   = ((m_hi - m_lo) * SLOT * m_step) / AF;
      sx[0] = m_lo * SLOT + off;
      sx[1] = m_hi * SLOT - off;
      hh[0] = hgt(m_snap[m_lo]);
      hh[1] = hgt(m_snap[m_hi]);
      for (int k = 0; k < 2; k++)
        for (int c = sx[k]; c < sx[k] + SLOT - GAP; c++)
          for (int y = 0; y < BHM; y++) fb[y][c] = C_BLACK;
      for (int k = 0; k < 2; k++)
        if (hh[k] > 0)
          for (int c = sx[k]; c < sx[k] + SLOT - GAP; c++) fb[BHM-hh[k]][c] = C_WHITE;
      for (int k = 0; k < 2; k++)
        for (int c = sx[k]; c < sx[k] + SLOT - GAP; c++)
          for (int r = 1; r < hh[k]; r++) fb[BHM-r][c] = C_RED;
    end
    for (int x = 0; x < W; x++) fb[BHM][x] = C_WHITE;
    for (int x = 0; x < W; x++) begin
      if (done) begin
        if (x < sweep * SLOT) fb[BHM+1][x] = C_GREEN;
      end else if (sorting) begin
        if (x >= 32 && x <= 63) fb[BHM+1][x] = C_YELLOW;
      end else if (x >= 40 && x <= 55) begin
        fb[BHM+1][x] = C_DGREY;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_snap[b] = 0;
    m_mode = MI; m_step = 0; m_sweep_frames = 0; m_pending = 0; m_lo = 0; m_hi = 0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    case (m_mode)
      MI: begin
        if (!m_pending) for (int b = 0; b < NB; b++) m_snap[b] = arr_val(b);
        if (done) begin
          m_mode = MS; m_pending = 0; m_sweep_frames = 0;
        end else if (m_pending) begin
          m_mode = MA; m_step = 0; m_pending = 0;
        end
      end
      MA: begin
        if (m_step == AF - 1) begin
          m_mode = MI;
          for (int b = 0; b < NB; b++) m_snap[b] = arr_val(b);
        end else m_step++;
      end
      default: begin
        if (!done) begin m_mode = MI; m_sweep_frames = 0; end
        else m_sweep_frames++;
      end
    endcase
  endtask

  task automatic set_array(input int a0, input int a1, input int a2,
                           input int a3, input int a4, input int a5);
    array_flat = {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endtask

  task automatic rand_array();
    for (int b = 0; b < NB; b++) array_flat[b*VW +: VW] = 8'($urandom_range(0, 255));
  endtask

  task automatic swap_pulse(input int a, input int b);
    @(negedge clk);
    compare_idx1 = 4'(a); compare_idx2 = 4'(b); swap_flag = 1'b1;
    if (!m_pending && m_mode != MA) begin
      m_pending = 1; m_lo = (a < b) ? a : b; m_hi = (a < b) ? b : a;
    end
    repeat (3) @(negedge clk);
    swap_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idx(input int idx, input logic [15:0] exp, input string tag);
    pixel_index = 14'(idx);
    @(negedge clk); @(negedge clk);
    check(tag, pixel_data, exp);
  endtask

  task automatic check_at(input int x, input int y, input logic [15:0] exp, input string tag);
    check_idx(y * W + x, exp, tag);
  endtask

  task automatic check_pixel(input int x, input int y, input string tag);
    paint();
    check_idx(y * W + x, fb[y][x], tag);
  endtask

  task automatic rand_pixels(input int n, input string tag);
    for (int i = 0; i < n; i++) check_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), tag);
  endtask

  task automatic check_busy(input string tag);
    check(tag, {15'd0, anim_busy}, {15'd0, m_mode == MA});
  endtask

  initial begin
    int a, b;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pixel", pixel_data, C_BLACK);
    check("reset_busy", {15'd0, anim_busy}, 16'd0);
    rst_n = 1'b1;

    set_array(255, 0, 128, 64, 32, 192);
    tick();
    check_at(0, 0, C_WHITE, "top_edge_full");
    check_at(20, 59, C_BLACK, "zero_bar");
    check_at(0, 60, C_WHITE, "baseline_0");
    check_at(50, 60, C_WHITE, "baseline_50");
    check_at(95, 60, C_WHITE, "baseline_95");
    check_at(40, 61, C_DGREY, "status_idle_in");
    check_at(39, 61, C_BLACK, "status_idle_out");
    check_at(33, 30, C_WHITE, "bar2_top");
    check_at(33, 31, C_BLUE, "bar2_fill");
    check_at(33, 29, C_BLACK, "bar2_above");
    check_at(46, 40, C_BLACK, "gap_col");
    check_at(10, 63, C_BLACK, "bottom_row");
    rand_pixels(15, "idle_rand");

    pixel_index = 14'(59 * W + 20);
    repeat (3) @(negedge clk);
    pixel_index = 14'(0);
    @(negedge clk);
    check("latency_1", pixel_data, C_BLACK);
    @(negedge clk);
    check("latency_2", pixel_data, C_WHITE);

    set_array(10, 20, 30, 40, 50, 60);
    check_at(0, 0, C_WHITE, "frozen_until_tick");
    rand_pixels(6, "frozen_rand");
    tick();
    check_at(0, 0, C_BLACK, "reload_top");
    check_at(0, 58, C_WHITE, "reload_edge");
    check_at(0, 59, C_BLUE, "reload_fill");

    set_array(255, 200, 128, 64, 32, 192);
    tick();
    sorting = 1'b1; compare_idx1 = 4'd0; compare_idx2 = 4'd2;
    check_at(33, 31, C_YELLOW, "compared_yellow");
    rand_pixels(6, "sorting_rand");

    @(negedge clk);
    compare_idx1 = 4'd1; compare_idx2 = 4'd3; swap_flag = 1'b1;
    m_pending = 1; m_lo = 1; m_hi = 3;
    check_at(20, 59, C_RED, "swap_red_1");
    check_at(50, 59, C_RED, "swap_red_3");
    swap_flag = 1'b0;
    @(negedge clk);
    tick();
    for (int s = 0; s < AF; s++) begin
      check_busy("anim_busy_on");
      if (s == 2) sorting = 1'b0;
      if (s == 4) begin
        check_at(32, 59, C_RED, "slide_mid");
        check_at(20, 59, C_BLACK, "static_lo_hidden");
        check_at(50, 59, C_BLACK, "static_hi_hidden");
      end
      rand_pixels(3, "anim_rand");
      set_array(255, 64, 128, 200, 32, 192);
      tick();
    end
    check_busy("anim_busy_off");
    check_at(20, 45, C_WHITE, "post_swap_edge");
    check_at(20, 46, C_BLUE, "post_swap_fill");

    for (int k = 0; k < 3; k++) begin
      a = $urandom_range(0, NB - 1);
      b = (k == 1) ? a : $urandom_range(0, NB - 1);
      sorting = 1'b1;
      rand_array();
      swap_pulse(a, b);
      tick();
      for (int s = 0; s < AF; s++) begin
        check_busy("rand_anim_busy");
        rand_pixels(2, "rand_anim_pix");
        check_pixel($urandom_range(m_lo * SLOT, m_hi * SLOT + SLOT - GAP - 1),
                    $urandom_range(0, BHM - 1), "rand_anim_span");
        rand_array();
        tick();
      end
      check_busy("rand_anim_end");
      rand_pixels(3, "rand_post");
    end

    sorting = 1'b0;
    set_array(255, 200, 128, 64, 32, 192);
    tick();
    done = 1'b1;
    swap_pulse(0, 5);
    tick();
    check_busy("done_wins_busy");
    repeat (8) tick();
    check_at(0, 59, C_GREEN, "sweep_bar0");
    check_at(16, 59, C_GREEN, "sweep_bar1");
    check_at(32, 59, C_BLUE, "sweep_bar2");
    check_at(31, 61, C_GREEN, "sweep_status_end");
    check_at(32, 61, C_BLACK, "sweep_status_past");
    rand_pixels(6, "sweep_rand");
    repeat (20) tick();
    check_at(95, 61, C_GREEN, "sweep_saturated");
    check_at(80, 59, C_GREEN, "sweep_bar5");
    done = 1'b0;
    tick();
    check_at(40, 61, C_DGREY, "sweep_exit_status");
    check_at(0, 61, C_BLACK, "sweep_exit_clear");
    tick();
    check_busy("no_anim_after_done");

    sorting = 1'b1;
    swap_pulse(2, 4);
    tick();
    repeat (3) tick();
    check_busy("before_reset_busy");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_anim_reset_pixel", pixel_data, C_BLACK);
    check("mid_anim_reset_busy", {15'd0, anim_busy}, 16'd0);
    model_reset();
    rst_n = 1'b1;
    sorting = 1'b0;
    rand_pixels(4, "post_reset_rand");
    set_array(255, 200, 128, 64, 32, 192);
    tick();
    check_busy("post_reset_busy");
    check_at(0, 0, C_WHITE, "post_reset_idle");
    rand_pixels(6, "post_reset_frame");

    check_idx(W * H, C_BLACK, "oob_first");
    check_idx(16383, C_BLACK, "oob_max");
    check_idx(W * H - 1, C_BLACK, "last_pixel");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
